// File: rtl/kv_pkg.sv
// rtl/kv_pkg.sv - shared op/status/state codes and entry layout for the bucket engine
package kv_pkg;

  typedef enum logic [1:0] {
    OP_LOOKUP = 2'd0,
    OP_INSERT = 2'd1,
    OP_DELETE = 2'd2,
    OP_RSVD   = 2'd3
  } kv_op_e;

  typedef enum logic [2:0] {
    ST_HIT      = 3'd0,
    ST_MISS     = 3'd1,
    ST_INSERTED = 3'd2,
    ST_UPDATED  = 3'd3,
    ST_FULL     = 3'd4,
    ST_DELETED  = 3'd5
  } kv_status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_WR,
    S_RESP
  } kv_state_e;

  // Entry layout MSB->LSB: {valid, ts, key, val}
  function automatic int kv_entry_w(int ts_w, int key_len, int val_len);
    return 1 + ts_w + key_len + val_len;
  endfunction

  function automatic int kv_key_off(int val_len);
    return val_len;
  endfunction

  function automatic int kv_ts_off(int key_len, int val_len);
    return key_len + val_len;
  endfunction

  function automatic int kv_vld_off(int ts_w, int key_len, int val_len);
    return ts_w + key_len + val_len;
  endfunction

endpackage

// File: rtl/kv_bucket_engine_if.sv
// rtl/kv_bucket_engine_if.sv - request/response and DRAM command bundle of the bucket engine
interface kv_bucket_engine_if
  import kv_pkg::*;
#(
  parameter int KEY_LEN  = 80,
  parameter int VAL_LEN  = 32,
  parameter int TS_W     = 16,
  parameter int RAM_ADDR = 22
) ();
  localparam int ENTRY_W = kv_entry_w(TS_W, KEY_LEN, VAL_LEN);

  logic [TS_W-1:0]     cur_time;
  logic                req_valid;
  logic                req_ready;
  logic [1:0]          req_op;
  logic [KEY_LEN-1:0]  req_key;
  logic [VAL_LEN-1:0]  req_val;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [2:0]          rsp_status;
  logic [VAL_LEN-1:0]  rsp_val;
  logic [RAM_ADDR-1:0] mem_addr;
  logic                mem_rd_en;
  logic [ENTRY_W-1:0]  mem_rd_dout;
  logic                mem_rd_valid;
  logic                mem_wr_en;
  logic [ENTRY_W-1:0]  mem_wr_din;

  modport master (
    output cur_time, req_valid, req_op, req_key, req_val, rsp_ready, mem_rd_dout, mem_rd_valid,
    input  req_ready, rsp_valid, rsp_status, rsp_val, mem_addr, mem_rd_en, mem_wr_en, mem_wr_din
  );

  modport slave (
    input  cur_time, req_valid, req_op, req_key, req_val, rsp_ready, mem_rd_dout, mem_rd_valid,
    output req_ready, rsp_valid, rsp_status, rsp_val, mem_addr, mem_rd_en, mem_wr_en, mem_wr_din
  );
endinterface

// File: rtl/kv_hash_fold.sv
// rtl/kv_hash_fold.sv - XOR fold of a key into a bucket index, key zero-padded at the MSB
module kv_hash_fold #(
  parameter int KEY_LEN    = 80,
  parameter int TABLE_BITS = 10
) (
  input  logic [KEY_LEN-1:0]    key,
  output logic [TABLE_BITS-1:0] index
);
  localparam int NCH = (KEY_LEN + TABLE_BITS - 1) / TABLE_BITS;
  localparam int PW  = NCH * TABLE_BITS;

  logic [PW-1:0] padded;

  always_comb begin
    padded = PW'(key);
    index  = '0;
    for (int i = 0; i < NCH; i++) begin
      index = index ^ padded[i*TABLE_BITS +: TABLE_BITS];
    end
  end
endmodule

// File: rtl/kv_bucket_engine.sv
// rtl/kv_bucket_engine.sv - N-way hash bucket walker with TTL expiry, update-in-place and delete
module kv_bucket_engine
  import kv_pkg::*;
#(
  parameter int KEY_LEN    = 80,
  parameter int VAL_LEN    = 32,
  parameter int TS_W       = 16,
  parameter int WAYS       = 4,
  parameter int TABLE_BITS = 10,
  parameter int RAM_ADDR   = 22,
  parameter int BASE_ADDR  = 0,
  parameter int TTL        = 1000
) (
  input logic              clk,
  input logic              rst,
  kv_bucket_engine_if.slave bus
);
  localparam int ENTRY_W = kv_entry_w(TS_W, KEY_LEN, VAL_LEN);
  localparam int VLD_BIT = kv_vld_off(TS_W, KEY_LEN, VAL_LEN);
  localparam int TS_LSB  = kv_ts_off(KEY_LEN, VAL_LEN);
  localparam int KEY_LSB = kv_key_off(VAL_LEN);
  localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int WAY_SH  = $clog2(WAYS);
  localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(WAYS - 1);
  localparam logic [31:0]      TTL_U    = 32'(TTL);

  kv_state_e           state_q, state_d;
  kv_op_e              op_q, op_d;
  kv_status_e          status_q, status_d;
  logic [KEY_LEN-1:0]  key_q, key_d;
  logic [VAL_LEN-1:0]  val_q, val_d;
  logic [TS_W-1:0]     time_q, time_d;
  logic [WAY_W-1:0]    way_q, way_d;
  logic                free_vld_q, free_vld_d;
  logic [WAY_W-1:0]    free_way_q, free_way_d;
  logic [WAY_W-1:0]    wr_way_q, wr_way_d;
  logic [ENTRY_W-1:0]  wr_data_q, wr_data_d;
  logic [VAL_LEN-1:0]  rsp_val_q, rsp_val_d;

  logic [TABLE_BITS-1:0] idx;
  logic                  e_vld, e_exp, e_free, e_match;
  logic [TS_W-1:0]       e_ts, age;
  logic [KEY_LEN-1:0]    e_key;
  logic [VAL_LEN-1:0]    e_val;
  logic [ENTRY_W-1:0]    new_entry;
  logic [WAY_W-1:0]      sel_way;
  logic [RAM_ADDR-1:0]   way_addr;

  kv_hash_fold #(.KEY_LEN(KEY_LEN), .TABLE_BITS(TABLE_BITS)) u_hash (
    .key   (key_q),
    .index (idx)
  );

  // Ages are taken against the time latched at accept so one request sees a consistent clock
  always_comb begin
    e_vld     = bus.mem_rd_dout[VLD_BIT];
    e_ts      = bus.mem_rd_dout[TS_LSB +: TS_W];
    e_key     = bus.mem_rd_dout[KEY_LSB +: KEY_LEN];
    e_val     = bus.mem_rd_dout[VAL_LEN-1:0];
    age       = time_q - e_ts;
    e_exp     = e_vld && (TTL_U != 32'd0) && (32'(age) >= TTL_U);
    e_free    = !e_vld || e_exp;
    e_match   = e_vld && !e_exp && (e_key == key_q);
    new_entry = {1'b1, time_q, key_q, val_q};
    sel_way   = (state_q == S_WR) ? wr_way_q : way_q;
    way_addr  = RAM_ADDR'(BASE_ADDR) + (RAM_ADDR'(idx) << WAY_SH) + RAM_ADDR'(sel_way);
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    status_d   = status_q;
    key_d      = key_q;
    val_d      = val_q;
    time_d     = time_q;
    way_d      = way_q;
    free_vld_d = free_vld_q;
    free_way_d = free_way_q;
    wr_way_d   = wr_way_q;
    wr_data_d  = wr_data_q;
    rsp_val_d  = rsp_val_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          op_d       = (bus.req_op == OP_RSVD) ? OP_LOOKUP : kv_op_e'(bus.req_op);
          key_d      = bus.req_key;
          val_d      = bus.req_val;
          time_d     = bus.cur_time;
          way_d      = '0;
          free_vld_d = 1'b0;
          free_way_d = '0;
          state_d    = S_RD;
        end
      end
      S_RD: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.mem_rd_valid) begin
          if (e_match) begin
            rsp_val_d = e_val;
            case (op_q)
              OP_INSERT: begin
                wr_data_d = new_entry;
                wr_way_d  = way_q;
                status_d  = ST_UPDATED;
                state_d   = S_WR;
              end
              OP_DELETE: begin
                wr_data_d = {1'b0, bus.mem_rd_dout[ENTRY_W-2:0]};
                wr_way_d  = way_q;
                status_d  = ST_DELETED;
                state_d   = S_WR;
              end
              default: begin
                status_d = ST_HIT;
                state_d  = S_RESP;
              end
            endcase
          end else begin
            if (e_free && !free_vld_q) begin
              free_vld_d = 1'b1;
              free_way_d = way_q;
            end
            if (way_q != LAST_WAY) begin
              way_d   = way_q + WAY_W'(1);
              state_d = S_RD;
            end else begin
              rsp_val_d = '0;
              // free_vld_q lags by one read, so the last way's own free flag is folded in here
              if (op_q == OP_INSERT && (free_vld_q || e_free)) begin
                wr_data_d = new_entry;
                wr_way_d  = free_vld_q ? free_way_q : way_q;
                status_d  = ST_INSERTED;
                state_d   = S_WR;
              end else begin
                status_d = (op_q == OP_INSERT) ? ST_FULL : ST_MISS;
                state_d  = S_RESP;
              end
            end
          end
        end
      end
      S_WR: state_d = S_RESP;
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= OP_LOOKUP;
      status_q   <= ST_HIT;
      key_q      <= '0;
      val_q      <= '0;
      time_q     <= '0;
      way_q      <= '0;
      free_vld_q <= 1'b0;
      free_way_q <= '0;
      wr_way_q   <= '0;
      wr_data_q  <= '0;
      rsp_val_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      status_q   <= status_d;
      key_q      <= key_d;
      val_q      <= val_d;
      time_q     <= time_d;
      way_q      <= way_d;
      free_vld_q <= free_vld_d;
      free_way_q <= free_way_d;
      wr_way_q   <= wr_way_d;
      wr_data_q  <= wr_data_d;
      rsp_val_q  <= rsp_val_d;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE) && !rst;
  assign bus.mem_rd_en  = (state_q == S_RD);
  assign bus.mem_wr_en  = (state_q == S_WR);
  assign bus.mem_addr   = (state_q == S_RD || state_q == S_WR) ? way_addr : '0;
  assign bus.mem_wr_din = (state_q == S_WR) ? wr_data_q : '0;
  assign bus.rsp_valid  = (state_q == S_RESP);
  assign bus.rsp_status = (state_q == S_RESP) ? status_q : 3'd0;
  assign bus.rsp_val    = (state_q == S_RESP) ? rsp_val_q : '0;
endmodule

// File: tb/tb_kv_bucket_engine.sv
// tb/tb_kv_bucket_engine.sv - directed bench for kv_bucket_engine with a latency-2 memory model
module tb_kv_bucket_engine;
  localparam int EW = 129;
  localparam int L  = 2;
  localparam logic [1:0] OP_LK = 2'd0, OP_IN = 2'd1, OP_DL = 2'd2;
  localparam logic [2:0] R_HIT = 3'd0, R_MISS = 3'd1, R_INS = 3'd2, R_UPD = 3'd3, R_FULL = 3'd4, R_DEL = 3'd5;
  localparam logic [79:0] K0 = 80'h3;
  localparam logic [79:0] K1 = 80'h3 ^ (80'h5 << 10) ^ (80'h5 << 20);
  localparam logic [79:0] K2 = 80'h3 ^ (80'h1 << 10) ^ (80'h1 << 70);
  localparam logic [79:0] K3 = 80'h3 ^ (80'h7 << 30) ^ (80'h7 << 40);
  localparam logic [79:0] K4 = 80'h3 ^ (80'h9 << 50) ^ (80'h9 << 60);
  localparam logic [79:0] K5 = 80'h3 ^ (80'h21 << 10) ^ (80'h21 << 20);
  localparam logic [79:0] K7 = 80'h7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  kv_bucket_engine_if #(.KEY_LEN(80), .VAL_LEN(32), .TS_W(16), .RAM_ADDR(22)) bus ();

  kv_bucket_engine #(
    .KEY_LEN(80), .VAL_LEN(32), .TS_W(16), .WAYS(4), .TABLE_BITS(10),
    .RAM_ADDR(22), .BASE_ADDR(0), .TTL(100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;

  bit [EW-1:0]  mem [0:4095];
  bit           p1;
  bit [EW-1:0]  p1_d;
  int           rd_cnt = 0;
  int           wr_cnt = 0;
  logic [21:0]  rd_log [$];
  logic [21:0]  last_wr_addr;
  logic [EW-1:0] last_wr_data;

  always @(posedge clk) begin
    p1               <= bus.mem_rd_en;
    p1_d             <= mem[bus.mem_addr[11:0]];
    bus.mem_rd_valid <= p1;
    bus.mem_rd_dout  <= p1 ? p1_d : '0;
    if (bus.mem_rd_en) begin
      rd_cnt <= rd_cnt + 1;
      rd_log.push_back(bus.mem_addr);
    end
    if (bus.mem_wr_en) begin
      mem[bus.mem_addr[11:0]] <= bus.mem_wr_din;
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= bus.mem_addr;
      last_wr_data <= bus.mem_wr_din;
    end
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] ent(input logic v, input logic [15:0] ts,
                                         input logic [79:0] k, input logic [31:0] val);
    return {v, ts, k, val};
  endfunction

  task automatic xact(input logic [1:0] op, input logic [79:0] key, input logic [31:0] val,
                      input logic [15:0] t, input bit ack,
                      output logic [2:0] st, output logic [31:0] rv, output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) check("req_ready_timeout", 0, 1);
    bus.cur_time  = t;
    bus.req_op    = op;
    bus.req_key   = key;
    bus.req_val   = val;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.rsp_valid && lat < 200);
    if (!bus.rsp_valid) check("rsp_timeout", 0, 1);
    st = bus.rsp_status;
    rv = bus.rsp_val;
    if (ack) begin
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus.rsp_ready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [2:0]  st;
    logic [31:0] rv;
    int          lat, w0, r0, rb;
    bit          stable, rdy_seen, wr_seen;
    logic [79:0] kk [3];
    kk = '{K1, K2, K3};

    rst = 1'b1;
    bus.req_valid = 1'b0; bus.rsp_ready = 1'b0; bus.cur_time = '0;
    bus.req_op = '0; bus.req_key = '0; bus.req_val = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_outputs", {bus.rsp_valid, bus.rsp_status, bus.rsp_val, bus.mem_addr,
                          bus.mem_rd_en, bus.mem_wr_en, bus.mem_wr_din}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_req_ready", bus.req_ready, 1);

    // first insert walks all four ways then writes way 0
    w0 = wr_cnt;
    xact(OP_IN, K0, 32'h1000_0000, 16'd0, 1, st, rv, lat);
    check("ins_status", st, R_INS);
    check("ins_rsp_val", rv, 0);
    check("ins_addr", last_wr_addr, 12);
    check("ins_data", last_wr_data, ent(1'b1, 16'd0, K0, 32'h1000_0000));
    check("ins_wr_count", wr_cnt - w0, 1);

    xact(OP_LK, K0, 32'd0, 16'd0, 1, st, rv, lat);
    check("lk_status", st, R_HIT);
    check("lk_val", rv, 32'h1000_0000);
    check("lk_latency_way0", lat, (0 + 1) * (L + 1) + 1);

    xact(OP_IN, K0, 32'h2000_0000, 16'd0, 1, st, rv, lat);
    check("upd_status", st, R_UPD);
    check("upd_old_val", rv, 32'h1000_0000);
    check("upd_addr", last_wr_addr, 12);
    check("upd_latency", lat, (0 + 1) * (L + 1) + 2);
    xact(OP_LK, K0, 32'd0, 16'd0, 1, st, rv, lat);
    check("upd_lk_val", rv, 32'h2000_0000);

    for (int i = 0; i < 3; i++) begin
      xact(OP_IN, kk[i], 32'h100 + i, 16'd0, 1, st, rv, lat);
      check("coll_status", st, R_INS);
      check("coll_addr", last_wr_addr, 13 + i);
    end
    w0 = wr_cnt;
    xact(OP_IN, K4, 32'h4444, 16'd0, 1, st, rv, lat);
    check("full_status", st, R_FULL);
    check("full_rsp_val", rv, 0);
    check("full_no_write", wr_cnt - w0, 0);

    xact(OP_LK, K0, 32'd0, 16'd99, 1, st, rv, lat);
    check("ttl_99_status", st, R_HIT);
    check("ttl_99_val", rv, 32'h2000_0000);
    xact(OP_LK, K0, 32'd0, 16'd100, 1, st, rv, lat);
    check("ttl_100_status", st, R_MISS);
    xact(OP_IN, K4, 32'h4444, 16'd100, 1, st, rv, lat);
    check("reuse_status", st, R_INS);
    check("reuse_addr", last_wr_addr, 12);

    // timestamp near the top of the range; ages wrap through zero
    xact(OP_IN, K5, 32'h5555, 16'hFFC0, 1, st, rv, lat);
    check("wrap_ins_addr", last_wr_addr, 12);
    check("wrap_ins_data", last_wr_data, ent(1'b1, 16'hFFC0, K5, 32'h5555));
    xact(OP_LK, K5, 32'd0, 16'h0023, 1, st, rv, lat);
    check("wrap_age99_status", st, R_HIT);
    check("wrap_age99_val", rv, 32'h5555);
    xact(OP_LK, K5, 32'd0, 16'h0024, 1, st, rv, lat);
    check("wrap_age100_status", st, R_MISS);

    xact(OP_IN, K0, 32'h3000_0000, 16'h0030, 1, st, rv, lat);
    check("reins_addr", last_wr_addr, 12);
    xact(OP_DL, K0, 32'd0, 16'h0030, 1, st, rv, lat);
    check("del_status", st, R_DEL);
    check("del_val", rv, 32'h3000_0000);
    check("del_addr", last_wr_addr, 12);
    check("del_data", last_wr_data, ent(1'b0, 16'h0030, K0, 32'h3000_0000));
    check("del_mem_valid", mem[12][EW-1], 0);
    w0 = wr_cnt;
    xact(OP_DL, K0, 32'd0, 16'h0030, 1, st, rv, lat);
    check("redel_status", st, R_MISS);
    check("redel_no_write", wr_cnt - w0, 0);

    r0 = rd_cnt;
    rb = rd_log.size();
    xact(OP_LK, K7, 32'd0, 16'h0030, 1, st, rv, lat);
    check("empty_status", st, R_MISS);
    check("empty_reads", rd_cnt - r0, 4);
    for (int j = 0; j < 4; j++) check("empty_rd_addr", rd_log[rb + j], 28 + j);
    check("empty_latency", lat, 4 * (L + 1) + 1);

    xact(OP_IN, K7, 32'hABCD, 16'h0030, 1, st, rv, lat);
    check("k7_ins_addr", last_wr_addr, 28);

    // response held while rsp_ready stays low
    xact(OP_LK, K7, 32'd0, 16'h0030, 0, st, rv, lat);
    check("hold_status", st, R_HIT);
    stable = 1'b1;
    rdy_seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_status !== R_HIT || bus.rsp_val !== 32'hABCD) stable = 1'b0;
      if (bus.req_ready) rdy_seen = 1'b1;
    end
    check("hold_stable", stable, 1);
    check("hold_req_ready_low", rdy_seen, 0);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;

    // reset while the engine waits on read data for an update
    w0 = wr_cnt;
    @(negedge clk);
    bus.cur_time = 16'h0030; bus.req_op = OP_IN; bus.req_key = K7;
    bus.req_val = 32'h1111; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("mid_rd_en", bus.mem_rd_en, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_outputs", {bus.rsp_valid, bus.rsp_status, bus.rsp_val, bus.mem_addr,
                              bus.mem_rd_en, bus.mem_wr_en, bus.mem_wr_din}, 0);
    check("mid_rst_req_ready", bus.req_ready, 0);
    rst = 1'b0;
    wr_seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.mem_wr_en || bus.rsp_valid) wr_seen = 1'b1;
    end
    check("mid_no_write_or_rsp", wr_seen, 0);
    check("mid_wr_count", wr_cnt - w0, 0);
    check("mid_req_ready", bus.req_ready, 1);
    xact(OP_LK, K7, 32'd0, 16'h0030, 1, st, rv, lat);
    check("mid_after_status", st, R_HIT);
    check("mid_after_val", rv, 32'hABCD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
